awgn_sweep_ctrl: RTL and testbench
==================================

Name: awgn_sweep_ctrl

Overview:
Sequencer for automated in-FPGA BER-vs-noise sweeps. Steps the channel's noise_magnitude from a start value to a stop value, flushes the channel pipeline after each change, then counts received symbols and bit errors over a fixed window. Emits one result record per sweep point. Sits between the control register bank and the AWGN channel / receiver error checker.

Parameters:
NOISE_MAG_WIDTH, 8, width of noise_magnitude and sweep bounds
CNT_WIDTH, 24, width of symbol and error counters
ERR_IN_WIDTH, 3, width of per-symbol bit-error count input (0..4 for 16-QAM)
SETTLE_CYCLES, 8, cycles rx data is ignored after a magnitude change (must be ≥ 4-cycle channel latency + RX latency)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle sweep start; ignored while busy
abort  in  1  cancel sweep; highest priority
mag_start  in  NOISE_MAG_WIDTH  first magnitude
mag_step  in  NOISE_MAG_WIDTH  increment per point
mag_stop  in  NOISE_MAG_WIDTH  last allowed magnitude (inclusive)
num_symbols  in  CNT_WIDTH  symbols per point
rx_valid  in  1  receiver symbol strobe
rx_bit_errs  in  ERR_IN_WIDTH  bit errors in current symbol, qualified by rx_valid
noise_magnitude  out  NOISE_MAG_WIDTH  drives channel noise control
busy  out  1  sweep in progress
point_valid  out  1  one-cycle pulse: point_* fields are new
point_mag  out  NOISE_MAG_WIDTH  magnitude of reported point
point_errs  out  CNT_WIDTH  accumulated bit errors
point_syms  out  CNT_WIDTH  symbols counted
sweep_done  out  1  one-cycle pulse at normal sweep completion

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0. All outputs registered.
- Config (mag_start/step/stop, num_symbols) latched on accepted start; later input changes have no effect until the next sweep. num_symbols==0 latched as 1.
- States: IDLE, SETTLE, MEASURE, REPORT, DONE.
- IDLE: start=1 → SETTLE; cur_mag=mag_start. Next cycle: busy=1, noise_magnitude=mag_start.
- SETTLE: settle counter runs SETTLE_CYCLES cycles; rx_valid/rx_bit_errs ignored; sym/err accumulators cleared on entry; then → MEASURE.
- MEASURE: each cycle with rx_valid=1: sym_cnt+1, err_acc+rx_bit_errs (zero-extended). err_acc saturates at all-ones, never wraps. When accepted symbol makes sym_cnt==num_symbols → REPORT (that symbol included; further rx_valid in REPORT not counted).
- REPORT (1 cycle): point_valid=1, point_mag=cur_mag, point_errs=err_acc, point_syms=sym_cnt. point_* hold until next REPORT or reset. Next magnitude computed at NOISE_MAG_WIDTH+1 bits: nxt=cur_mag+mag_step. If mag_step==0, nxt>mag_stop, or nxt overflows NOISE_MAG_WIDTH → DONE; else cur_mag=nxt, noise_magnitude=nxt, → SETTLE.
- mag_start>mag_stop: exactly one point at mag_start, then DONE.
- DONE (1 cycle): sweep_done=1; → IDLE with busy=0, noise_magnitude=0.
- abort=1 in any non-IDLE state: next cycle IDLE, busy=0, noise_magnitude=0, no point_valid, no sweep_done; point_* retain last completed point. abort in IDLE: no effect. abort and start together in IDLE: start ignored.
- start while busy: ignored, no config relatch.
- Async reset mid-sweep: immediate return to reset values.
- Latency: start at cycle T → first counted rx_valid at T+1+SETTLE_CYCLES at earliest.

Test Plan:
- mag_start=10, step=20, stop=50, num_symbols=100, rx_valid every cycle, rx_bit_errs=1 → 3 point_valid pulses, mags 10/30/50, errs=100, syms=100 each; one sweep_done; noise_magnitude 0 afterwards.
- rx_valid asserted during SETTLE with rx_bit_errs=4 → none counted; point_errs reflects only MEASURE-window symbols.
- mag_start=250, step=10, stop=255 → single point at 250 (overflow/stop terminates); mag_step=0 → single point at mag_start; mag_start=100, stop=50 → single point at 100.
- CNT_WIDTH=4 bench, num_symbols=15, rx_bit_errs=4 each → point_errs saturates at 15, point_syms=15.
- abort mid-MEASURE on second point → busy low next cycle, noise_magnitude=0, no further point_valid, no sweep_done, point_* still hold first point; new start then runs a full sweep.
- start pulsed while busy with different config → ignored; sweep completes with original config.

Source files
------------

// File: rtl/awgn_sweep_ctrl_if.sv
// Control/status bundle between the register bank, the AWGN channel and the
// receiver error checker, as seen by the sweep sequencer.
interface awgn_sweep_ctrl_if #(
    parameter int NOISE_MAG_WIDTH = 8,
    parameter int CNT_WIDTH       = 24,
    parameter int ERR_IN_WIDTH    = 3
) ();
    logic                       start;
    logic                       abort;
    logic [NOISE_MAG_WIDTH-1:0] mag_start;
    logic [NOISE_MAG_WIDTH-1:0] mag_step;
    logic [NOISE_MAG_WIDTH-1:0] mag_stop;
    logic [CNT_WIDTH-1:0]       num_symbols;
    logic                       rx_valid;
    logic [ERR_IN_WIDTH-1:0]    rx_bit_errs;
    logic [NOISE_MAG_WIDTH-1:0] noise_magnitude;
    logic                       busy;
    logic                       point_valid;
    logic [NOISE_MAG_WIDTH-1:0] point_mag;
    logic [CNT_WIDTH-1:0]       point_errs;
    logic [CNT_WIDTH-1:0]       point_syms;
    logic                       sweep_done;

    modport master (
        output start, abort, mag_start, mag_step, mag_stop, num_symbols,
               rx_valid, rx_bit_errs,
        input  noise_magnitude, busy, point_valid, point_mag, point_errs,
               point_syms, sweep_done
    );

    modport slave (
        input  start, abort, mag_start, mag_step, mag_stop, num_symbols,
               rx_valid, rx_bit_errs,
        output noise_magnitude, busy, point_valid, point_mag, point_errs,
               point_syms, sweep_done
    );
endinterface

// File: rtl/awgn_sweep_ctrl.sv
// BER-vs-noise sweep sequencer: steps noise_magnitude, flushes the channel,
// then counts symbols/bit errors per point and reports one record per point.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; noise_magnitude held at 0
// S_SETTLE  | channel/rx pipeline flushing after a magnitude change
// S_MEASURE | counting rx symbols and bit errors for the current point
// S_REPORT  | point_valid pulse; pick next magnitude or finish
// S_DONE    | sweep_done pulse, then back to idle
module awgn_sweep_ctrl #(
    parameter int NOISE_MAG_WIDTH = 8,
    parameter int CNT_WIDTH       = 24,
    parameter int ERR_IN_WIDTH    = 3,
    parameter int SETTLE_CYCLES   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    awgn_sweep_ctrl_if.slave sw
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_REPORT  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]                 r_state;
    logic [NOISE_MAG_WIDTH-1:0] r_cur_mag;
    logic [NOISE_MAG_WIDTH-1:0] r_step;
    logic [NOISE_MAG_WIDTH-1:0] r_stop;
    logic [CNT_WIDTH-1:0]       r_num_syms;
    logic [SW-1:0]              r_settle_cnt;
    logic [CNT_WIDTH-1:0]       r_sym_cnt;
    logic [CNT_WIDTH-1:0]       r_err_acc;

    logic [NOISE_MAG_WIDTH-1:0] r_noise_mag;
    logic                       r_busy;
    logic                       r_point_valid;
    logic [NOISE_MAG_WIDTH-1:0] r_point_mag;
    logic [CNT_WIDTH-1:0]       r_point_errs;
    logic [CNT_WIDTH-1:0]       r_point_syms;
    logic                       r_sweep_done;

    logic [NOISE_MAG_WIDTH:0]   w_nxt_mag;
    logic                       w_last_point;
    logic [CNT_WIDTH-1:0]       w_sym_inc;
    logic [CNT_WIDTH:0]         w_err_sum;
    logic [CNT_WIDTH-1:0]       w_err_sat;

    // one extra bit so a step past the top of the magnitude range is caught
    assign w_nxt_mag    = {1'b0, r_cur_mag} + {1'b0, r_step};
    assign w_last_point = (r_step == '0) || w_nxt_mag[NOISE_MAG_WIDTH] ||
                          (w_nxt_mag[NOISE_MAG_WIDTH-1:0] > r_stop);

    assign w_sym_inc = r_sym_cnt + CNT_WIDTH'(1);
    assign w_err_sum = {1'b0, r_err_acc} + (CNT_WIDTH+1)'(sw.rx_bit_errs);
    assign w_err_sat = w_err_sum[CNT_WIDTH] ? '1 : w_err_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cur_mag     <= '0;
            r_step        <= '0;
            r_stop        <= '0;
            r_num_syms    <= '0;
            r_settle_cnt  <= '0;
            r_sym_cnt     <= '0;
            r_err_acc     <= '0;
            r_noise_mag   <= '0;
            r_busy        <= 1'b0;
            r_point_valid <= 1'b0;
            r_point_mag   <= '0;
            r_point_errs  <= '0;
            r_point_syms  <= '0;
            r_sweep_done  <= 1'b0;
        end else begin
            r_point_valid <= 1'b0;
            r_sweep_done  <= 1'b0;
            if (sw.abort && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_noise_mag <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (sw.start && !sw.abort) begin
                            r_cur_mag    <= sw.mag_start;
                            r_noise_mag  <= sw.mag_start;
                            r_step       <= sw.mag_step;
                            r_stop       <= sw.mag_stop;
                            r_num_syms   <= (sw.num_symbols == '0) ? CNT_WIDTH'(1)
                                                                   : sw.num_symbols;
                            r_settle_cnt <= SETTLE_LOAD;
                            r_sym_cnt    <= '0;
                            r_err_acc    <= '0;
                            r_busy       <= 1'b1;
                            r_state      <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt == '0) begin
                            r_state <= S_MEASURE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - SW'(1);
                        end
                    end
                    S_MEASURE: begin
                        if (sw.rx_valid) begin
                            r_sym_cnt <= w_sym_inc;
                            r_err_acc <= w_err_sat;
                            if (w_sym_inc == r_num_syms) begin
                                r_point_valid <= 1'b1;
                                r_point_mag   <= r_cur_mag;
                                r_point_errs  <= w_err_sat;
                                r_point_syms  <= w_sym_inc;
                                r_state       <= S_REPORT;
                            end
                        end
                    end
                    S_REPORT: begin
                        if (w_last_point) begin
                            r_sweep_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_cur_mag    <= w_nxt_mag[NOISE_MAG_WIDTH-1:0];
                            r_noise_mag  <= w_nxt_mag[NOISE_MAG_WIDTH-1:0];
                            r_settle_cnt <= SETTLE_LOAD;
                            r_sym_cnt    <= '0;
                            r_err_acc    <= '0;
                            r_state      <= S_SETTLE;
                        end
                    end
                    S_DONE: begin
                        r_busy      <= 1'b0;
                        r_noise_mag <= '0;
                        r_state     <= S_IDLE;
                    end
                    default: begin
                        r_busy      <= 1'b0;
                        r_noise_mag <= '0;
                        r_state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sw.noise_magnitude = r_noise_mag;
    assign sw.busy            = r_busy;
    assign sw.point_valid     = r_point_valid;
    assign sw.point_mag       = r_point_mag;
    assign sw.point_errs      = r_point_errs;
    assign sw.point_syms      = r_point_syms;
    assign sw.sweep_done      = r_sweep_done;
endmodule

// File: tb/tb_awgn_sweep_ctrl.sv
// Bench for awgn_sweep_ctrl: table of sweep configs plus random sweeps, all
// checked against a per-point model built from the stimulus record.
module tb_awgn_sweep_ctrl;
    localparam int SETTLE = 8;
    localparam int MAXC   = 6000;
    localparam longint ERRMAX = (64'd1 << 24) - 1;
    localparam int MAGMAX = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    awgn_sweep_ctrl_if #(.NOISE_MAG_WIDTH(8), .CNT_WIDTH(24), .ERR_IN_WIDTH(3)) sw_a ();
    awgn_sweep_ctrl_if #(.NOISE_MAG_WIDTH(8), .CNT_WIDTH(4),  .ERR_IN_WIDTH(3)) sw_b ();

    awgn_sweep_ctrl #(.NOISE_MAG_WIDTH(8), .CNT_WIDTH(24), .ERR_IN_WIDTH(3),
                      .SETTLE_CYCLES(SETTLE))
        dut (.clk(clk), .rst_n(rst_n), .sw(sw_a));

    awgn_sweep_ctrl #(.NOISE_MAG_WIDTH(8), .CNT_WIDTH(4), .ERR_IN_WIDTH(3),
                      .SETTLE_CYCLES(SETTLE))
        dut4 (.clk(clk), .rst_n(rst_n), .sw(sw_b));

    int n_tests = 0;
    int n_fail  = 0;

    bit       stim_v [MAXC];
    bit [2:0] stim_e [MAXC];

    typedef struct {
        int ms, st, sp, ns, pct, emin, emax;
        bit s4;
        int npts, last_mag;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic scramble_cfg();
        sw_a.mag_start   = 8'($urandom_range(0, 255));
        sw_a.mag_step    = 8'($urandom_range(0, 255));
        sw_a.mag_stop    = 8'($urandom_range(0, 255));
        sw_a.num_symbols = 24'($urandom_range(0, 1000));
    endtask

    // Runs one sweep on dut; cycle 0 is the start cycle.
    task automatic run_sweep(input int ms, input int st, input int sp, input int ns,
                             input int pct, input int emin, input int emax,
                             input bit settle4, input int abort_off, input bit restart,
                             output int obs_n, output int obs_last);
        int e_cyc[$];
        int e_mag[$];
        longint e_err[$];
        int e_sym[$];
        int m, nse, kk, n, w, done_c, a, busy_last, np_exp, pi, nd, kend, p;
        longint acc;
        bit exp_busy, model_ok;

        for (int k = 0; k < MAXC; k++) begin
            stim_v[k] = ($urandom_range(1, 100) <= pct);
            stim_e[k] = 3'($urandom_range(emin, emax));
        end
        if (settle4)
            for (int k = 0; k <= SETTLE; k++) begin
                stim_v[k] = 1'b1;
                stim_e[k] = 3'd4;
            end

        // model: each point ignores SETTLE cycles, then takes the first nse valid symbols
        nse = (ns == 0) ? 1 : ns;
        m = ms;
        w = 1 + SETTLE;
        done_c = -1;
        model_ok = 1'b1;
        for (int q = 0; q < 300; q++) begin
            n = 0; acc = 0; kk = w;
            while (n < nse && kk < MAXC - 10) begin
                if (stim_v[kk]) begin
                    n++;
                    acc += longint'(stim_e[kk]);
                end
                kk++;
            end
            if (n < nse) begin
                model_ok = 1'b0;
                break;
            end
            e_cyc.push_back(kk);
            e_mag.push_back(m);
            e_err.push_back((acc > ERRMAX) ? ERRMAX : acc);
            e_sym.push_back(nse);
            if (st == 0 || m + st > sp || m + st > MAGMAX) begin
                done_c = kk + 1;
                break;
            end
            m = m + st;
            w = kk + 1 + SETTLE;
        end
        obs_n = 0;
        obs_last = -1;
        if (!model_ok || done_c < 0) begin
            chk("model_budget", 0, 1);
            return;
        end

        a = (abort_off >= 0) ? e_cyc[0] + abort_off : MAXC;
        np_exp = 0;
        foreach (e_cyc[i]) if (e_cyc[i] <= a) np_exp++;
        if (done_c > a) done_c = -1;
        busy_last = (done_c >= 0) ? done_c : a;
        kend = busy_last + 3;

        sw_a.mag_start   = 8'(ms);
        sw_a.mag_step    = 8'(st);
        sw_a.mag_stop    = 8'(sp);
        sw_a.num_symbols = 24'(ns);
        pi = 0;
        nd = 0;
        for (int k = 0; k <= kend; k++) begin
            @(negedge clk);
            exp_busy = (k >= 1 && k <= busy_last);
            chk("busy", sw_a.busy, exp_busy);
            if (!exp_busy) begin
                chk("noise_idle", sw_a.noise_magnitude, 0);
            end else if (k != done_c) begin
                p = 0;
                while (p < e_cyc.size() - 1 && k > e_cyc[p]) p++;
                chk("noise", sw_a.noise_magnitude, e_mag[p]);
            end
            if (sw_a.point_valid) begin
                if (pi < np_exp) begin
                    chk("pt_cycle", k, e_cyc[pi]);
                    chk("pt_mag", sw_a.point_mag, e_mag[pi]);
                    chk("pt_errs", sw_a.point_errs, e_err[pi]);
                    chk("pt_syms", sw_a.point_syms, e_sym[pi]);
                end else begin
                    chk("extra_point", 1, 0);
                end
                pi++;
                obs_last = int'(sw_a.point_mag);
            end
            if (sw_a.sweep_done) begin
                nd++;
                chk("done_cycle", k, done_c);
            end
            sw_a.start = (k == 0) || (restart && k == 5);
            sw_a.abort = (k == a);
            sw_a.rx_valid = stim_v[k];
            sw_a.rx_bit_errs = stim_e[k];
            if (k >= 1) scramble_cfg();
        end
        sw_a.start = 1'b0;
        sw_a.abort = 1'b0;
        sw_a.rx_valid = 1'b0;
        sw_a.rx_bit_errs = '0;
        obs_n = pi;
        chk("npts_model", pi, np_exp);
        chk("done_count", nd, (done_c >= 0) ? 1 : 0);
        if (np_exp > 0) begin
            chk("hold_mag", sw_a.point_mag, e_mag[np_exp-1]);
            chk("hold_errs", sw_a.point_errs, e_err[np_exp-1]);
            chk("hold_syms", sw_a.point_syms, e_sym[np_exp-1]);
        end
    endtask

    initial begin
        int on, ol, found;
        sw_a.start = 0; sw_a.abort = 0; sw_a.rx_valid = 0; sw_a.rx_bit_errs = '0;
        sw_a.mag_start = '0; sw_a.mag_step = '0; sw_a.mag_stop = '0; sw_a.num_symbols = '0;
        sw_b.start = 0; sw_b.abort = 0; sw_b.rx_valid = 0; sw_b.rx_bit_errs = '0;
        sw_b.mag_start = '0; sw_b.mag_step = '0; sw_b.mag_stop = '0; sw_b.num_symbols = '0;

        //          ms   st   sp   ns  pct emin emax s4  npts last
        tbl[0] = '{ 10,  20,  50, 100, 100, 1, 1, 1'b1, 3,  50};
        tbl[1] = '{250,  10, 255,  20, 100, 0, 4, 1'b0, 1, 250};
        tbl[2] = '{ 77,   0, 200,  10,  60, 0, 4, 1'b0, 1,  77};
        tbl[3] = '{100,   5,  50,  10,  70, 0, 4, 1'b0, 1, 100};
        tbl[4] = '{  0, 255, 255,   5, 100, 0, 4, 1'b0, 2, 255};
        tbl[5] = '{200,  28, 255,   8,  50, 0, 4, 1'b0, 2, 228};
        tbl[6] = '{  3,   7,  24,  30,  40, 0, 4, 1'b0, 4,  24};
        tbl[7] = '{  5,   1,   5,   0,  80, 0, 4, 1'b0, 1,   5};

        repeat (3) @(negedge clk);
        chk("rst_busy", sw_a.busy, 0);
        chk("rst_noise", sw_a.noise_magnitude, 0);
        chk("rst_pvalid", sw_a.point_valid, 0);
        chk("rst_pmag", sw_a.point_mag, 0);
        chk("rst_perrs", sw_a.point_errs, 0);
        chk("rst_psyms", sw_a.point_syms, 0);
        chk("rst_done", sw_a.sweep_done, 0);
        chk("rst4_busy", sw_b.busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_sweep(tbl[i].ms, tbl[i].st, tbl[i].sp, tbl[i].ns, tbl[i].pct,
                      tbl[i].emin, tbl[i].emax, tbl[i].s4, -1, 1'b0, on, ol);
            chk("tbl_npts", on, tbl[i].npts);
            chk("tbl_last_mag", ol, tbl[i].last_mag);
        end

        // abort during the second point's measurement window, then a full sweep
        run_sweep(10, 20, 50, 40, 100, 0, 4, 1'b0, SETTLE + 15, 1'b0, on, ol);
        chk("abort_npts", on, 1);
        chk("abort_last_mag", ol, 10);
        run_sweep(10, 20, 50, 100, 100, 1, 1, 1'b0, -1, 1'b0, on, ol);
        chk("after_abort_npts", on, 3);

        // start pulsed mid-sweep with a different config is ignored
        run_sweep(10, 20, 50, 30, 70, 0, 4, 1'b0, -1, 1'b1, on, ol);
        chk("restart_npts", on, 3);
        chk("restart_last_mag", ol, 50);

        for (int r = 0; r < 6; r++) begin
            int st;
            st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(20, 80);
            run_sweep($urandom_range(0, 255), st, $urandom_range(0, 255),
                      $urandom_range(0, 40), $urandom_range(30, 100), 0, 4,
                      1'b0, -1, 1'b0, on, ol);
        end

        // abort+start together in idle, and lone abort in idle
        @(negedge clk);
        sw_a.mag_start = 8'd33; sw_a.mag_step = 8'd1; sw_a.mag_stop = 8'd40;
        sw_a.num_symbols = 24'd3;
        sw_a.start = 1'b1; sw_a.abort = 1'b1;
        @(negedge clk);
        sw_a.start = 1'b0; sw_a.abort = 1'b0;
        chk("idle_abort_start_busy", sw_a.busy, 0);
        chk("idle_abort_start_noise", sw_a.noise_magnitude, 0);
        sw_a.abort = 1'b1;
        @(negedge clk);
        sw_a.abort = 1'b0;
        chk("idle_abort_busy", sw_a.busy, 0);

        // saturating error accumulator on the 4-bit counter instance
        sw_b.mag_start = 8'd9; sw_b.mag_step = 8'd0; sw_b.mag_stop = 8'd9;
        sw_b.num_symbols = 4'd15; sw_b.start = 1'b1;
        sw_b.rx_valid = 1'b1; sw_b.rx_bit_errs = 3'd4;
        @(negedge clk);
        sw_b.start = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (sw_b.point_valid) found = 1;
        end
        chk("sat_found", found, 1);
        chk("sat_errs", sw_b.point_errs, 15);
        chk("sat_syms", sw_b.point_syms, 15);
        chk("sat_mag", sw_b.point_mag, 9);
        sw_b.rx_valid = 1'b0;

        // asynchronous reset in the middle of a sweep
        @(negedge clk);
        sw_a.mag_start = 8'd40; sw_a.mag_step = 8'd10; sw_a.mag_stop = 8'd200;
        sw_a.num_symbols = 24'd5; sw_a.start = 1'b1;
        @(negedge clk);
        sw_a.start = 1'b0; sw_a.rx_valid = 1'b1; sw_a.rx_bit_errs = 3'd2;
        repeat (30) @(negedge clk);
        chk("pre_reset_busy", sw_a.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", sw_a.busy, 0);
        chk("async_rst_noise", sw_a.noise_magnitude, 0);
        chk("async_rst_pmag", sw_a.point_mag, 0);
        chk("async_rst_perrs", sw_a.point_errs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sw_a.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", sw_a.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
